// File: rtl/wb_txn_monitor_if.sv
// rtl/wb_txn_monitor_if.sv - Wishbone bus signals snooped by the transaction monitor

interface wb_txn_monitor_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic                  ack_i;
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_wr_i;
  logic [DATA_WIDTH-1:0] dat_rd_i;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_wr_i,
    input  ack_i, dat_rd_i
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_wr_i,
    output ack_i, dat_rd_i
  );

  // Passive observer: sees every bus wire, drives none.
  modport monitor (
    input cyc_i, stb_i, we_i, ack_i, adr_i, dat_wr_i, dat_rd_i
  );
endinterface

// File: rtl/wb_txn_monitor.sv
// rtl/wb_txn_monitor.sv - Wishbone completion capture with wait-state latency and record FIFO

module wb_txn_monitor #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int LAT_WIDTH  = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  wb_txn_monitor_if.monitor            wb,
  input  logic                         flt_en_i,
  input  logic [ADDR_WIDTH-1:0]        flt_mask_i,
  input  logic [ADDR_WIDTH-1:0]        flt_match_i,
  input  logic                         cap_wr_en_i,
  input  logic                         cap_rd_en_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic                         m_we_o,
  output logic [ADDR_WIDTH-1:0]        m_adr_o,
  output logic [DATA_WIDTH-1:0]        m_dat_o,
  output logic [LAT_WIDTH-1:0]         m_lat_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [15:0]                  ovf_cnt_o,
  output logic                         drop_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = 1 + ADDR_WIDTH + DATA_WIDTH + LAT_WIDTH;
  localparam logic [LAT_WIDTH-1:0] LAT_MAX = '1;
  localparam logic [CW-1:0]        FULL_COUNT = CW'(DEPTH);

  logic [LAT_WIDTH-1:0]  wait_cnt;
  logic [RW-1:0]         mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [RW-1:0]         rec_in;
  logic [RW-1:0]         head;

  logic strobe;
  logic complete;
  logic type_en;
  logic addr_hit;
  logic accept;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic dropped;

  assign strobe   = wb.cyc_i & wb.stb_i;
  assign complete = strobe & wb.ack_i;
  assign type_en  = wb.we_i ? cap_wr_en_i : cap_rd_en_i;
  assign addr_hit = !flt_en_i || ((wb.adr_i & flt_mask_i) == (flt_match_i & flt_mask_i));
  assign accept   = complete & type_en & addr_hit;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign pop     = !empty & m_ready_i;
  // A full FIFO still takes a record when the head leaves in the same cycle.
  assign push    = accept & (!full | pop);
  assign dropped = accept & full & !pop;

  assign rec_in = {wb.we_i, wb.adr_i, (wb.we_i ? wb.dat_wr_i : wb.dat_rd_i), wait_cnt};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (strobe && !wb.ack_i) begin
      wait_cnt <= (wait_cnt == LAT_MAX) ? wait_cnt : wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem[wr_ptr] <= rec_in;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf_cnt_o <= '0;
      drop_o    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      drop_o <= dropped;
      if (dropped && ovf_cnt_o != 16'hFFFF) begin
        ovf_cnt_o <= ovf_cnt_o + 16'd1;
      end
    end
  end

  // Head fields read as zero while empty so stale storage never leaks out.
  assign head = empty ? '0 : mem[rd_ptr];

  assign m_valid_o = !empty;
  assign count_o   = count;
  assign m_lat_o   = head[LAT_WIDTH-1:0];
  assign m_dat_o   = head[LAT_WIDTH +: DATA_WIDTH];
  assign m_adr_o   = head[LAT_WIDTH+DATA_WIDTH +: ADDR_WIDTH];
  assign m_we_o    = head[RW-1];

endmodule

// File: tb/tb_wb_txn_monitor.sv
// tb/tb_wb_txn_monitor.sv - directed self-checking bench for wb_txn_monitor

module tb_wb_txn_monitor;

  logic       clk;
  logic       rst;
  logic       flt_en;
  logic [1:0] flt_mask;
  logic [1:0] flt_match;
  logic       cap_wr_en;
  logic       cap_rd_en;
  logic       m_valid;
  logic       m_ready;
  logic       m_we;
  logic [1:0] m_adr;
  logic [7:0] m_dat;
  logic [7:0] m_lat;
  logic [4:0] count;
  logic [15:0] ovf_cnt;
  logic       drop;

  int pass_cnt;
  int total_cnt;

  wb_txn_monitor_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) wb ();

  wb_txn_monitor #(
    .ADDR_WIDTH(2), .DATA_WIDTH(8), .DEPTH(16), .LAT_WIDTH(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wb(wb),
    .flt_en_i(flt_en), .flt_mask_i(flt_mask), .flt_match_i(flt_match),
    .cap_wr_en_i(cap_wr_en), .cap_rd_en_i(cap_rd_en),
    .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_we_o(m_we), .m_adr_o(m_adr), .m_dat_o(m_dat), .m_lat_o(m_lat),
    .count_o(count), .ovf_cnt_o(ovf_cnt), .drop_o(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.ack_i = 1'b0;
  endtask

  // One transaction: `waits` strobe cycles without ack, then the acked cycle.
  task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [7:0] dat, input int waits);
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = we; wb.adr_i = adr;
    wb.dat_wr_i = we ? dat : 8'h00;
    wb.dat_rd_i = we ? 8'h00 : dat;
    wb.ack_i = 1'b0;
    repeat (waits) cycle();
    wb.ack_i = 1'b1;
    cycle();
    bus_idle();
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    total_cnt++; if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", m_valid); else pass_cnt++;
    total_cnt++; if (ovf_cnt !== 16'd0) $display("FAIL reset_ovf got %0d want 0", ovf_cnt); else pass_cnt++;
    total_cnt++; if (drop !== 1'b0) $display("FAIL reset_drop got %b want 0", drop); else pass_cnt++;
    total_cnt++;
    if ({m_we, m_adr, m_dat, m_lat} !== 19'd0)
      $display("FAIL reset_head got we=%b adr=%0d dat=%h lat=%0d want all 0", m_we, m_adr, m_dat, m_lat);
    else pass_cnt++;
    pop_one();
    total_cnt++; if (count !== 5'd0) $display("FAIL ready_empty_count got %0d want 0", count); else pass_cnt++;
  endtask

  task automatic test_write_latency();
    wb_xfer(1'b1, 2'd2, 8'hA5, 3);
    total_cnt++; if (m_valid !== 1'b1) $display("FAIL wr_valid got %b want 1", m_valid); else pass_cnt++;
    total_cnt++; if (m_we !== 1'b1) $display("FAIL wr_we got %b want 1", m_we); else pass_cnt++;
    total_cnt++; if (m_adr !== 2'd2) $display("FAIL wr_adr got %0d want 2", m_adr); else pass_cnt++;
    total_cnt++; if (m_dat !== 8'hA5) $display("FAIL wr_dat got %h want a5", m_dat); else pass_cnt++;
    total_cnt++; if (m_lat !== 8'd3) $display("FAIL wr_lat got %0d want 3", m_lat); else pass_cnt++;
    pop_one();
    total_cnt++; if (count !== 5'd0) $display("FAIL wr_pop_count got %0d want 0", count); else pass_cnt++;
  endtask

  task automatic test_filter();
    logic [1:0] adrs [3];
    logic [7:0] dats [3];
    adrs[0] = 2'd0; adrs[1] = 2'd1; adrs[2] = 2'd3;
    dats[0] = 8'h11; dats[1] = 8'h22; dats[2] = 8'h33;
    flt_en = 1'b1; flt_mask = 2'b11; flt_match = 2'b01;
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b0; wb.ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb.adr_i = adrs[i]; wb.dat_rd_i = dats[i];
      cycle();
    end
    bus_idle();
    cycle();
    total_cnt++; if (count !== 5'd1) $display("FAIL flt_count got %0d want 1", count); else pass_cnt++;
    total_cnt++; if (m_adr !== 2'd1) $display("FAIL flt_adr got %0d want 1", m_adr); else pass_cnt++;
    total_cnt++; if (m_dat !== 8'h22) $display("FAIL flt_dat got %h want 22", m_dat); else pass_cnt++;
    total_cnt++; if (m_lat !== 8'd0) $display("FAIL flt_lat got %0d want 0", m_lat); else pass_cnt++;
    total_cnt++; if (m_we !== 1'b0) $display("FAIL flt_we got %b want 0", m_we); else pass_cnt++;
    total_cnt++; if (ovf_cnt !== 16'd0) $display("FAIL flt_ovf got %0d want 0", ovf_cnt); else pass_cnt++;
    pop_one();
    flt_en = 1'b0;
  endtask

  task automatic test_cap_enable();
    cap_rd_en = 1'b0;
    wb_xfer(1'b0, 2'd1, 8'h77, 1);
    total_cnt++; if (count !== 5'd0) $display("FAIL caprd_off_count got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (drop !== 1'b0) $display("FAIL caprd_off_drop got %b want 0", drop); else pass_cnt++;
    cap_rd_en = 1'b1;
    // ack without strobe is not a completion
    wb.cyc_i = 1'b1; wb.stb_i = 1'b0; wb.ack_i = 1'b1; wb.we_i = 1'b1;
    cycle();
    bus_idle();
    total_cnt++; if (count !== 5'd0) $display("FAIL stray_ack_count got %0d want 0", count); else pass_cnt++;
  endtask

  task automatic test_overflow();
    int drops;
    drops = 0;
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1; wb.ack_i = 1'b1;
    for (int i = 0; i < 18; i++) begin
      wb.adr_i = 2'(i); wb.dat_wr_i = 8'(i);
      cycle();
      if (drop === 1'b1) drops++;
    end
    bus_idle();
    cycle();
    if (drop === 1'b1) drops++;
    total_cnt++; if (count !== 5'd16) $display("FAIL ovf_count got %0d want 16", count); else pass_cnt++;
    total_cnt++; if (ovf_cnt !== 16'd2) $display("FAIL ovf_cnt got %0d want 2", ovf_cnt); else pass_cnt++;
    total_cnt++; if (drops !== 2) $display("FAIL ovf_drop_pulses got %0d want 2", drops); else pass_cnt++;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if (m_valid !== 1'b1 || m_dat !== 8'(i))
        $display("FAIL ovf_drain_%0d got valid=%b dat=%h want valid=1 dat=%h", i, m_valid, m_dat, 8'(i));
      else pass_cnt++;
      cycle();
    end
    m_ready = 1'b0;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL ovf_drained_valid got %b want 0", m_valid); else pass_cnt++;
  endtask

  task automatic test_full_pop();
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1; wb.ack_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wb.adr_i = 2'(i); wb.dat_wr_i = 8'h40 + 8'(i);
      cycle();
    end
    wb.dat_wr_i = 8'hEE;
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
    bus_idle();
    total_cnt++; if (count !== 5'd16) $display("FAIL fullpop_count got %0d want 16", count); else pass_cnt++;
    total_cnt++; if (drop !== 1'b0) $display("FAIL fullpop_drop got %b want 0", drop); else pass_cnt++;
    total_cnt++; if (ovf_cnt !== 16'd2) $display("FAIL fullpop_ovf got %0d want 2", ovf_cnt); else pass_cnt++;
    m_ready = 1'b1;
    for (int i = 1; i < 17; i++) begin
      total_cnt++;
      if (i < 16) begin
        if (m_dat !== 8'h40 + 8'(i)) $display("FAIL fullpop_drain_%0d got %h want %h", i, m_dat, 8'h40 + 8'(i));
        else pass_cnt++;
      end else begin
        if (m_dat !== 8'hEE) $display("FAIL fullpop_last got %h want ee", m_dat);
        else pass_cnt++;
      end
      cycle();
    end
    m_ready = 1'b0;
    total_cnt++; if (count !== 5'd0) $display("FAIL fullpop_empty got %0d want 0", count); else pass_cnt++;
  endtask

  task automatic test_saturation();
    wb_xfer(1'b0, 2'd3, 8'h5A, 300);
    total_cnt++; if (m_lat !== 8'd255) $display("FAIL sat_lat got %0d want 255", m_lat); else pass_cnt++;
    total_cnt++; if (m_dat !== 8'h5A) $display("FAIL sat_dat got %h want 5a", m_dat); else pass_cnt++;
    pop_one();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) wb_xfer(1'b1, 2'(i), 8'h80 + 8'(i), 0);
    total_cnt++; if (count !== 5'd5) $display("FAIL rstmid_pre_count got %0d want 5", count); else pass_cnt++;
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1; wb.adr_i = 2'd2; wb.dat_wr_i = 8'hC3; wb.ack_i = 1'b0;
    cycle();
    cycle();
    rst = 1'b1; wb.ack_i = 1'b1;
    cycle();
    rst = 1'b0; wb.ack_i = 1'b0;
    total_cnt++; if (count !== 5'd0) $display("FAIL rstmid_count got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", m_valid); else pass_cnt++;
    total_cnt++; if (ovf_cnt !== 16'd0) $display("FAIL rstmid_ovf got %0d want 0", ovf_cnt); else pass_cnt++;
    cycle();
    total_cnt++; if (count !== 5'd0) $display("FAIL rstmid_no_capture got %0d want 0", count); else pass_cnt++;
    wb.ack_i = 1'b1;
    cycle();
    bus_idle();
    total_cnt++; if (count !== 5'd1) $display("FAIL rstmid_post_count got %0d want 1", count); else pass_cnt++;
    total_cnt++; if (m_lat !== 8'd1) $display("FAIL rstmid_lat got %0d want 1", m_lat); else pass_cnt++;
    total_cnt++; if (m_dat !== 8'hC3) $display("FAIL rstmid_dat got %h want c3", m_dat); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b1;
    flt_en = 1'b0; flt_mask = 2'b00; flt_match = 2'b00;
    cap_wr_en = 1'b1; cap_rd_en = 1'b1;
    m_ready = 1'b0;
    wb.we_i = 1'b0; wb.adr_i = 2'd0; wb.dat_wr_i = 8'h00; wb.dat_rd_i = 8'h00;
    bus_idle();

    test_reset();
    test_write_latency();
    test_filter();
    test_cap_enable();
    test_overflow();
    test_full_pop();
    test_saturation();
    test_reset_mid();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_txn_monitor.md
WB_TXN_MONITOR -- requirements
Module: wb_txn_monitor

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 2, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, Wishbone data width.
REQ-003 SHALL have parameter DEPTH, default 16, capture FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter LAT_WIDTH, default 8, wait-state counter width.
REQ-005 Single clock domain; rst_i is synchronous, active-high; all ports below sampled/driven on the rising edge of clk_i.
REQ-006 clk_i  in  1  system clock.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 cyc_i, stb_i, we_i, ack_i  in  1 each  snooped Wishbone cycle, strobe, write-enable and acknowledge.
REQ-009 adr_i  in  ADDR_WIDTH  snooped address.
REQ-010 dat_wr_i / dat_rd_i  in  DATA_WIDTH each  snooped master-to-slave / slave-to-master data.
REQ-011 flt_en_i  in  1  address filter enable; flt_mask_i, flt_match_i  in  ADDR_WIDTH each  filter mask and match value.
REQ-012 cap_wr_en_i / cap_rd_en_i  in  1 each  capture writes / capture reads.
REQ-013 m_valid_o  out  1  record available; m_ready_i  in  1  consumer accepts record.
REQ-014 m_we_o  out  1; m_adr_o  out  ADDR_WIDTH; m_dat_o  out  DATA_WIDTH; m_lat_o  out  LAT_WIDTH  head record fields.
REQ-015 count_o  out  clog2(DEPTH+1)  FIFO occupancy.
REQ-016 ovf_cnt_o  out  16  dropped-record count; drop_o  out  1  one-cycle drop pulse.

Function
REQ-017 Completion = cycle with cyc_i & stb_i & ack_i all high; ack_i without cyc_i & stb_i SHALL be ignored.
REQ-018 Back-to-back completions (ack_i high on consecutive cycles) SHALL each be a separate completion.
REQ-019 Wait counter: increments each cycle cyc_i & stb_i & !ack_i; cleared on completion and whenever !(cyc_i & stb_i); saturates at 2^LAT_WIDTH-1.
REQ-020 Record latency = wait counter value in the completion cycle (0 when ack_i arrives in the first strobe cycle).
REQ-021 Record data = dat_wr_i when we_i=1, dat_rd_i when we_i=0; m_we_o, m_adr_o from the completion cycle.
REQ-022 Accept when (type enabled: we_i ? cap_wr_en_i : cap_rd_en_i) and (!flt_en_i or (adr_i & flt_mask_i) == (flt_match_i & flt_mask_i)); otherwise silently discard, no drop.
REQ-023 Accepted record SHALL be written to FIFO at the completion edge; visible at m_valid_o/head fields the next cycle when FIFO was empty (latency 1).
REQ-024 m_valid_o = (count_o != 0); pop when m_valid_o & m_ready_i; head fields stable while m_valid_o & !m_ready_i.
REQ-025 FIFO full and accepted completion with simultaneous pop: write accepted, count_o unchanged.
REQ-026 FIFO full, accepted completion, no pop: record dropped, drop_o=1 next cycle, ovf_cnt_o increments, saturating at 16'hFFFF.
REQ-027 Simultaneous push and pop on non-empty non-full FIFO: count_o unchanged, order preserved (FIFO order = completion order).
REQ-028 Pointers SHALL wrap modulo DEPTH without record loss or duplication.
REQ-029 m_ready_i while empty SHALL have no effect.

Reset
REQ-030 rst_i=1 SHALL: empty FIFO, count_o=0, m_valid_o=0, ovf_cnt_o=0, drop_o=0, wait counter=0, m_we_o/m_adr_o/m_dat_o/m_lat_o=0.
REQ-031 Completion in a cycle with rst_i=1 SHALL NOT be captured; reset mid-transaction restarts wait count from 0 on the cycle after reset release.

Verification
REQ-032 Write adr=2 dat=8'hA5, ack on 4th strobe cycle, filters off, both caps on -> next cycle m_valid_o=1, m_we_o=1, m_adr_o=2, m_dat_o=8'hA5, m_lat_o=3.
REQ-033 Three reads adr=0,1,3 acked back-to-back, dat_rd 8'h11/22/33, flt_en=1 mask=2'b11 match=2'b01 -> only adr=1 record, m_dat_o=8'h22, m_lat_o=0.
REQ-034 DEPTH=16, m_ready_i=0, 18 accepted writes -> count_o=16, ovf_cnt_o=2, drop_o pulsed twice; drain yields first 16 in order.
REQ-035 FIFO full, m_ready_i=1 on same cycle as completion -> count_o stays 16, drop_o=0, new record last out.
REQ-036 Strobe held 300 cycles before ack, LAT_WIDTH=8 -> m_lat_o=255.
REQ-037 rst_i pulsed with 5 records queued and strobe pending -> count_o=0, m_valid_o=0, ovf_cnt_o=0; ack in reset cycle not captured; next ack 2 cycles after release gives m_lat_o=1.
